led_display_arbiter: RTL and testbench

Time-shares the board's single 8-digit seven-segment display between several 32-bit requesters (PC, register probe, memory probe, debug). It grants one requester at a time for a guaranteed minimum dwell and inserts a blank gap between owners. Its data and enable outputs drive the display multiplexer's 32-bit data input and active-low enable directly.

---
 rtl/led_disp_pkg.sv | 15 +
 rtl/led_arb_pick.sv | 47 ++++
 rtl/led_display_arbiter.sv | 136 +++++++++++++
 tb/tb_led_display_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Imported by led_arb_pick and led_display_arbiter.
package led_disp_pkg;

    localparam int DISP_W  = 32;
    localparam int MAX_REQ = 8;
    localparam int PTR_W   = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_BLANK
    } disp_state_t;

endpackage

// File: rtl/led_arb_pick.sv
// Combinational winner picker for the display arbiter.
// LED_DISPLAY_ARB_RR_EN selects round-robin, otherwise lowest index wins.
module led_arb_pick
    import led_disp_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic             valid
);

    logic [NREQ-1:0] above;

`ifdef LED_DISPLAY_ARB_RR_EN
    always_comb begin
        above = '0;
        for (int j = 0; j < NREQ; j++) begin
            above[j] = (j > int'(ptr));
        end
    end
`else
    logic ptr_unused;
    assign above      = '0;
    assign ptr_unused = ^ptr;
`endif

    // Indices above the pointer are searched first, then wrap to 0.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!valid && req[j] && above[j]) begin
                win[j] = 1'b1;
                valid  = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!valid && req[j]) begin
                win[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_display_arbiter.sv
// Time-shares one 8-digit display between NREQ requesters.
// Define LED_DISPLAY_ARB_RR_EN for round-robin instead of fixed priority.
module led_display_arbiter
    import led_disp_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DWELL = 1048576,
    parameter int BLANK = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [DISP_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        grant,
    output logic [DISP_W-1:0]      disp_data,
    output logic                   disp_enable_n,
    output logic                   busy
);

    localparam int DW_W = $clog2(DWELL + 1);
    localparam int BW_W = $clog2(BLANK + 1);
    localparam logic [DW_W-1:0] DWELL_MAX  = DW_W'(DWELL);
    localparam logic [BW_W-1:0] BLANK_LAST = BW_W'(BLANK - 1);

    disp_state_t       state, state_nxt;
    logic [NREQ-1:0]   grant_nxt;
    logic [DISP_W-1:0] data_nxt;
    logic              enable_nxt;
    logic [DW_W-1:0]   dwell_cnt, dwell_nxt;
    logic [BW_W-1:0]   blank_cnt, blank_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [NREQ-1:0]   pick_win;
    logic              pick_valid;
    logic [DISP_W-1:0] pick_data, own_data;
    logic              own_req, others, start;

    led_arb_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .win   (pick_win),
        .valid (pick_valid)
    );

    always_comb begin
        pick_data = '0;
        own_data  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick_win[j]) pick_data = req_data[j*DISP_W +: DISP_W];
            if (grant[j])    own_data  = req_data[j*DISP_W +: DISP_W];
        end
    end

    // grant is one-hot in SHOW, so it doubles as the owner mask.
    assign own_req = |(req & grant);
    assign others  = |(req & ~grant);
    assign busy    = (state != S_IDLE);

`ifdef LED_DISPLAY_ARB_RR_EN
    logic [PTR_W-1:0] pick_idx;

    always_comb begin
        pick_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick_win[j]) pick_idx = PTR_W'(j);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)     ptr <= PTR_W'(NREQ - 1);
        else if (start) ptr <= pick_idx;
    end
`else
    assign ptr = PTR_W'(NREQ - 1);
`endif

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        data_nxt   = disp_data;
        enable_nxt = disp_enable_n;
        dwell_nxt  = dwell_cnt;
        blank_nxt  = blank_cnt;
        start      = 1'b0;
        unique case (state)
            S_IDLE: begin
                start = pick_valid;
            end
            S_SHOW: begin
                if (dwell_cnt == DWELL_MAX && (!own_req || others)) begin
                    state_nxt  = S_BLANK;
                    grant_nxt  = '0;
                    enable_nxt = 1'b1;
                    blank_nxt  = '0;
                end else begin
                    if (dwell_cnt != DWELL_MAX) dwell_nxt = dwell_cnt + DW_W'(1);
                    if (own_req) data_nxt = own_data;
                end
            end
            S_BLANK: begin
                if (blank_cnt == BLANK_LAST) begin
                    start = pick_valid;
                    if (!pick_valid) state_nxt = S_IDLE;
                end else begin
                    blank_nxt = blank_cnt + BW_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (start) begin
            state_nxt  = S_SHOW;
            grant_nxt  = pick_win;
            data_nxt   = pick_data;
            enable_nxt = 1'b0;
            dwell_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            grant         <= '0;
            disp_data     <= '0;
            disp_enable_n <= 1'b1;
            dwell_cnt     <= '0;
            blank_cnt     <= '0;
        end else begin
            state         <= state_nxt;
            grant         <= grant_nxt;
            disp_data     <= data_nxt;
            disp_enable_n <= enable_nxt;
            dwell_cnt     <= dwell_nxt;
            blank_cnt     <= blank_nxt;
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Self-checking bench for led_display_arbiter: directed steps plus
// randomized traffic checked every cycle against a behavioural model.
module tb_led_display_arbiter;

    localparam int NREQ  = 4;
    localparam int DWELL = 8;
    localparam int BLANK = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req = '0;
    logic [127:0]   req_data = '0;
    logic [3:0]     grant;
    logic [31:0]    disp_data;
    logic           disp_enable_n;
    logic           busy;

    int compared = 0;
    int mismatched = 0;

    // Reference model: mode 0 = idle, 1 = showing, 2 = blank gap
    int          m_mode = 0;
    int          m_owner = 0;
    int          m_age = 0;
    int          m_gap = 0;
    int          m_last = NREQ - 1;
    logic [31:0] m_data = '0;

    led_display_arbiter #(
        .NREQ(NREQ), .DWELL(DWELL), .BLANK(BLANK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .disp_data     (disp_data),
        .disp_enable_n (disp_enable_n),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lane(int i);
        return 32'(req_data >> (32 * i));
    endfunction

    function automatic bit has(logic [3:0] r, int i);
        return ((r >> i) & 4'd1) != 4'd0;
    endfunction

    function automatic int pick(logic [3:0] r);
`ifdef LED_DISPLAY_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (has(r, (m_last + k) % NREQ)) return (m_last + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (has(r, k)) return k;
        end
`endif
        return -1;
    endfunction

    task automatic start_show(int w);
        m_mode  = 1;
        m_owner = w;
        m_age   = 0;
        m_last  = w;
        m_data  = lane(w);
    endtask

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_mode = 0; m_age = 0; m_gap = 0;
            m_last = NREQ - 1; m_data = '0;
        end else if (m_mode == 0) begin
            w = pick(req);
            if (w >= 0) start_show(w);
        end else if (m_mode == 1) begin
            if (m_age == DWELL &&
                (!has(req, m_owner) || (req & ~(4'd1 << m_owner)) != 0)) begin
                m_mode = 2;
                m_gap  = 0;
            end else begin
                if (has(req, m_owner)) m_data = lane(m_owner);
                if (m_age < DWELL) m_age++;
            end
        end else begin
            if (m_gap == BLANK - 1) begin
                w = pick(req);
                if (w >= 0) start_show(w);
                else m_mode = 0;
            end else begin
                m_gap++;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("m_grant", 32'(grant), m_mode == 1 ? (32'd1 << m_owner) : 32'd0);
        chk("m_data", disp_data, m_data);
        chk("m_enable_n", 32'(disp_enable_n), m_mode == 1 ? 32'd0 : 32'd1);
        chk("m_busy", 32'(busy), m_mode != 0 ? 32'd1 : 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    logic [31:0] frozen;
    logic [3:0]  exp_g;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_data", disp_data, 32'd0);
        chk("rst_en_n", 32'(disp_enable_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // 1: single request, one-cycle latency
        rst_n = 1'b1;
        req = 4'b0001;
        req_data[31:0] = 32'h12345678;
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_data", disp_data, 32'h12345678);
        chk("t1_en_n", 32'(disp_enable_n), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);

        // 2: data tracking and indefinite hold
        tick();
        tick();
        req_data[31:0] = 32'hDEADBEEF;
        tick();
        chk("t2_track", disp_data, 32'hDEADBEEF);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("t2_hold", 32'(grant), 32'h1);
        end

        // 3: two requesters from idle
        req = 4'b0000;
        wait_idle();
        req = 4'b0011;
        for (int i = 0; i < DWELL + 1; i++) begin
            tick();
            chk("t3_own0", 32'(grant), 32'h1);
        end
        for (int i = 0; i < BLANK; i++) begin
            tick();
            chk("t3_gap_g", 32'(grant), 32'd0);
            chk("t3_gap_en", 32'(disp_enable_n), 32'd1);
        end
        tick();
`ifdef LED_DISPLAY_ARB_RR_EN
        chk("t3_next", 32'(grant), 32'h2);
`else
        chk("t3_next", 32'(grant), 32'h1);
`endif

        // 4: owner drops early, display freezes, then idle
        req = 4'b0000;
        wait_idle();
        req = 4'b0001;
        req_data[31:0] = 32'hA5A50001;
        tick();
        req_data[31:0] = 32'hA5A50002;
        tick();
        frozen = 32'hA5A50002;
        req = 4'b0000;
        req_data[31:0] = 32'h0BADF00D;
        for (int i = 0; i < DWELL - 1; i++) begin
            tick();
            chk("t4_grant", 32'(grant), 32'h1);
            chk("t4_frozen", disp_data, frozen);
        end
        for (int i = 0; i < BLANK; i++) begin
            tick();
            chk("t4_gap_en", 32'(disp_enable_n), 32'd1);
            chk("t4_gap_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("t4_idle", 32'(busy), 32'd0);

        // 5: reset in the middle of SHOW
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = $urandom;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_data", disp_data, 32'd0);
        chk("t5_en_n", 32'(disp_enable_n), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t5_regrant", 32'(grant), 32'h1);

        // 6: all requesting; rotation under round-robin
        for (int r = 0; r < 5; r++) begin
`ifdef LED_DISPLAY_ARB_RR_EN
            exp_g = 4'd1 << (r % NREQ);
`else
            exp_g = 4'd1;
`endif
            for (int i = 0; i < DWELL + 1; i++) begin
                if (r != 0 || i != 0) tick();
                chk("t6_owner", 32'(grant), 32'(exp_g));
            end
            for (int i = 0; i < BLANK; i++) begin
                tick();
                chk("t6_gap", 32'(grant), 32'd0);
            end
        end

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(5) == 0) req = 4'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(2) == 0) req_data[32*i +: 32] = $urandom;
            end
            rst_n = ($urandom_range(199) != 0);
            tick();
        end
        rst_n = 1'b1;
        req = 4'b0000;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
